// File: rtl/blwl_prog_ctrl.sv
// rtl/blwl_prog_ctrl.sv - BL/WL program and read-back sequencer for a config SRAM bank
module blwl_prog_ctrl #(
    parameter int NUM_BL    = 8,
    parameter int NUM_WL    = 16,
    parameter int ADDR_W    = 4,
    parameter int WE_CYCLES = 2,
    parameter int RE_CYCLES = 1
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [NUM_BL-1:0] cmd_data,
    output logic [NUM_BL-1:0] BL,
    output logic              BL_OE,
    input  logic [NUM_BL-1:0] BL_IN,
    output logic [NUM_WL-1:0] WL,
    output logic [NUM_WL-1:0] WLR,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [NUM_BL-1:0] rsp_data,
    output logic              rsp_err
);
    localparam int MAX_CYC = (WE_CYCLES > RE_CYCLES) ? WE_CYCLES : RE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_READ, S_RESP
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cmd_ready_q;
    logic [NUM_BL-1:0] bl_q;
    logic              bl_oe_q;
    logic [NUM_WL-1:0] wl_q;
    logic [NUM_WL-1:0] wlr_q;
    logic              rsp_valid_q;
    logic [NUM_BL-1:0] rsp_data_q;
    logic              rsp_err_q;

    logic              addr_bad;
    logic [NUM_WL-1:0] cmd_sel;
    logic [NUM_WL-1:0] row_sel;

    assign addr_bad = (32'(cmd_addr) >= NUM_WL);
    assign cmd_sel  = NUM_WL'(1) << cmd_addr;
    assign row_sel  = NUM_WL'(1) << addr_q;

    // Every output is a register, so word lines never glitch during decode.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            cmd_ready_q <= 1'b0;
            bl_q        <= '0;
            bl_oe_q     <= 1'b0;
            wl_q        <= '0;
            wlr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        if (addr_bad) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            state_q     <= S_RESP;
                        end else if (cmd_write) begin
                            bl_q    <= cmd_data;
                            bl_oe_q <= 1'b1;
                            state_q <= S_SETUP;
                        end else begin
                            wlr_q   <= cmd_sel;
                            cnt_q   <= CNT_W'(RE_CYCLES);
                            state_q <= S_READ;
                        end
                    end
                end
                S_SETUP: begin
                    wl_q    <= row_sel;
                    cnt_q   <= CNT_W'(WE_CYCLES);
                    state_q <= S_PULSE;
                end
                S_PULSE: begin
                    if (cnt_q == CNT_W'(1)) begin
                        wl_q    <= '0;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    bl_q        <= '0;
                    bl_oe_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                    state_q     <= S_RESP;
                end
                S_READ: begin
                    // Bank output is captured in the last read cycle, while WLR is still high.
                    if (cnt_q == CNT_W'(1)) begin
                        wlr_q       <= '0;
                        rsp_data_q  <= BL_IN;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign BL        = bl_q;
    assign BL_OE     = bl_oe_q;
    assign WL        = wl_q;
    assign WLR       = wlr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_blwl_prog_ctrl.sv
// tb/tb_blwl_prog_ctrl.sv - scoreboard bench for blwl_prog_ctrl
module tb_blwl_prog_ctrl;
    localparam int NB = 8;
    localparam int NW = 16;
    localparam int AW = 4;
    localparam int WE = 2;
    localparam int RE = 1;

    logic          CK = 1'b0;
    logic          RSTN = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [NB-1:0] cmd_data = '0;
    logic [NB-1:0] BL;
    logic          BL_OE;
    logic [NB-1:0] BL_IN;
    logic [NW-1:0] WL;
    logic [NW-1:0] WLR;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [NB-1:0] rsp_data;
    logic          rsp_err;

    logic          c2_valid = 1'b0;
    logic          c2_ready;
    logic [AW-1:0] c2_addr = '0;
    logic [NB-1:0] bl2;
    logic          bl_oe2;
    logic [11:0]   wl2;
    logic [11:0]   wlr2;
    logic          r2_valid;
    logic [NB-1:0] r2_data;
    logic          r2_err;

    int            n_chk = 0;
    int            n_pass = 0;
    int            viol = 0;
    logic          rdy_dir = 1'b1;
    logic          rand_bp = 1'b0;
    logic [NB:0]   sb[$];
    logic [NB-1:0] ref_mem[NW] = '{default: '0};
    logic [NB-1:0] bank[NW] = '{default: '0};
    logic [NB-1:0] noise = '0;

    blwl_prog_ctrl #(.NUM_BL(NB), .NUM_WL(NW), .ADDR_W(AW), .WE_CYCLES(WE), .RE_CYCLES(RE)) u_dut (
        .CK(CK), .RSTN(RSTN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .BL(BL), .BL_OE(BL_OE), .BL_IN(BL_IN), .WL(WL), .WLR(WLR),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    blwl_prog_ctrl #(.NUM_BL(NB), .NUM_WL(12), .ADDR_W(AW), .WE_CYCLES(WE), .RE_CYCLES(RE)) u_dut12 (
        .CK(CK), .RSTN(RSTN), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_write(1'b1), .cmd_addr(c2_addr), .cmd_data(8'hFF),
        .BL(bl2), .BL_OE(bl_oe2), .BL_IN(8'hFF), .WL(wl2), .WLR(wlr2),
        .rsp_valid(r2_valid), .rsp_ready(1'b1), .rsp_data(r2_data), .rsp_err(r2_err)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural SRAM bank: WE cells latch BL, RE rows drive BL_IN, otherwise the lines float.
    always @(posedge CK) begin
        noise <= 8'($urandom);
        if (BL_OE) for (int r = 0; r < NW; r++) if (WL[r]) bank[r] <= BL;
    end

    always_comb begin
        BL_IN = noise;
        for (int r = 0; r < NW; r++) if (WLR[r]) BL_IN = bank[r];
    end

    always @(posedge CK) begin
        #1;
        rsp_ready = rand_bp ? 1'($urandom_range(0, 1)) : rdy_dir;
    end

    always @(negedge CK) begin : mon
        logic [NB:0] e;
        if (RSTN) begin
            if (!$onehot0(WL | WLR) || ((|WL) && (|WLR)) || (BL_OE && (|WLR)) || ((|WL) && !BL_OE))
                viol++;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_pending", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp", 32'({rsp_err, rsp_data}), 32'(e));
                end
            end
        end
    end

    function automatic logic [25:0] wr_exp(input int c, input logic [AW-1:0] a, input logic [NB-1:0] d);
        logic          oe;
        logic [NW-1:0] wl;
        oe = (c >= 1) && (c <= 2 + WE);
        wl = ((c >= 2) && (c <= 1 + WE)) ? (16'h1 << a) : 16'h0;
        return {oe, oe ? d : 8'h00, wl, 1'(c == 3 + WE)};
    endfunction

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [NB-1:0] d, output int waited);
        waited = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && waited < 100) begin
            @(negedge CK);
            waited++;
        end
        chk("accept", 32'(waited < 100), 1);
        sb.push_back(w ? 9'h000 : {1'b0, ref_mem[a]});
        if (w) ref_mem[a] = d;
        @(posedge CK);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_data  = 8'($urandom);
    endtask

    task automatic wr_seq(input logic [AW-1:0] a, input logic [NB-1:0] d);
        for (int c = 1; c <= 3 + WE; c++) begin
            @(negedge CK);
            chk($sformatf("wr_a%0d_c%0d", a, c), 32'({BL_OE, BL, WL, rsp_valid}), 32'(wr_exp(c, a, d)));
        end
    endtask

    initial begin
        int n;
        logic [NW:0] acc;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd1; cmd_data = 8'hFF;
        repeat (3) @(negedge CK);
        chk("rst_wl", 32'({WL, WLR}), 0);
        chk("rst_bl", 32'({BL, BL_OE, rsp_data, rsp_valid, rsp_err, cmd_ready}), 0);
        RSTN = 1'b1;
        @(negedge CK);
        chk("rst_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b0;
        @(negedge CK);

        send(1'b1, 4'd5, 8'hA5, n);  wr_seq(4'd5, 8'hA5);
        send(1'b1, 4'd15, 8'h3E, n); wr_seq(4'd15, 8'h3E);
        send(1'b1, 4'd0, 8'hC1, n);  wr_seq(4'd0, 8'hC1);
        send(1'b1, 4'd3, 8'h3C, n);  wr_seq(4'd3, 8'h3C);

        // Read with 10 cycles of backpressure and a competing command held on the port.
        rdy_dir = 1'b0;
        send(1'b0, 4'd3, 8'h00, n);
        @(negedge CK);
        chk("rd_wlr", 32'(WLR), 32'h0008);
        chk("rd_oe_wl", 32'({BL_OE, WL}), 0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd7; cmd_data = 8'h77;
        for (int c = 2; c <= 11; c++) begin
            @(negedge CK);
            chk($sformatf("bp_c%0d", c), 32'({rsp_valid, rsp_data, rsp_err, cmd_ready, BL_OE}),
                32'({1'b1, 8'h3C, 1'b0, 1'b0, 1'b0}));
        end
        rdy_dir = 1'b1;
        @(negedge CK);
        chk("bp_release", 32'({rsp_valid, cmd_ready}), 32'(2'b10));
        send(1'b1, 4'd7, 8'h77, n);
        chk("next_accept_wait", n, 1);
        wr_seq(4'd7, 8'h77);

        // Reset in the second pulse cycle.
        send(1'b1, 4'd2, 8'h5A, n);
        repeat (3) @(negedge CK);
        chk("pulse_wl", 32'(WL), 32'h0004);
        #1 RSTN = 1'b0;
        #1 chk("rst_async", 32'({WL, BL_OE, BL}), 0);
        void'(sb.pop_back());
        @(posedge CK);
        #1 RSTN = 1'b1;
        repeat (6) @(negedge CK);
        chk("rst_no_rsp", 32'(rsp_valid), 0);

        // Random writes then reads over every row, with random response backpressure.
        rand_bp = 1'b1;
        for (int r = 0; r < NW; r++) send(1'b1, 4'((r * 7) % NW), 8'($urandom), n);
        for (int r = 0; r < NW; r++) send(1'b0, 4'((r * 5) % NW), 8'h00, n);
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge CK);
            n++;
        end
        chk("sb_drain", 32'(sb.size()), 0);
        rand_bp = 1'b0;

        // Out-of-range row on the 12-row instance.
        c2_addr = 4'd13;
        c2_valid = 1'b1;
        n = 0;
        while (!c2_ready && n < 20) begin
            @(negedge CK);
            n++;
        end
        chk("err_accept", 32'(n < 20), 1);
        @(posedge CK);
        #1 c2_valid = 1'b0;
        acc = '0;
        @(negedge CK);
        chk("err_rsp", 32'({r2_valid, r2_err, r2_data}), 32'({1'b1, 1'b1, 8'h00}));
        acc = acc | {bl_oe2, 4'h0, wl2 | wlr2};
        for (int c = 0; c < 4; c++) begin
            @(negedge CK);
            acc = acc | {bl_oe2, 4'h0, wl2 | wlr2};
        end
        chk("err_quiet", 32'(acc), 0);
        chk("err_rsp_done", 32'(r2_valid), 0);

        chk("wl_invariants", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/blwl_prog_ctrl.md
# blwl_prog_ctrl

Sequencer for a bank of write-enabled configuration SRAM cells (SRAM/SRAM_RE style: WE word line, D bit line, RE read word line). Accepts one program or read-back command at a time through a valid/ready port. Drives shared bit lines and one-hot word lines with guaranteed setup, pulse and hold spacing. Returns one response per command. Sits between the configuration protocol front end and the BL/WL memory bank of a fabric tile.

## Interface
- NUM_BL, 8, bit lines per word (cells per row)
- NUM_WL, 16, word lines (rows)
- ADDR_W, 4, row address width; NUM_WL <= 2**ADDR_W
- WE_CYCLES, 2, word-line write pulse width in clocks (>= 1)
- RE_CYCLES, 1, read word-line width in clocks (>= 1); BL_IN sampled in last cycle
---
- CK  in  1  clock
- RSTN  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = program row, 0 = read back row
- cmd_addr  in  ADDR_W  row index
- cmd_data  in  NUM_BL  data to program (ignored on read)
- BL  out  NUM_BL  bit-line drive value
- BL_OE  out  1  bit-line drive enable (1 only during write sequence)
- BL_IN  in  NUM_BL  bit-line read-back value from bank
- WL  out  NUM_WL  one-hot write word lines (cell WE)
- WLR  out  NUM_WL  one-hot read word lines (cell RE)
- rsp_valid  out  1  response present, held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_data  out  NUM_BL  read-back data; 0 for writes and errors
- rsp_err  out  1  address out of range (cmd_addr >= NUM_WL)

## Operation
- States: IDLE, SETUP, PULSE, HOLD, READ, RESP.
- IDLE: cmd_ready = 1. On accept, register addr/data/write. If addr >= NUM_WL, go to RESP with rsp_err = 1 and no WL/WLR/BL_OE activity. Otherwise a write goes to SETUP and a read goes to READ.
- SETUP (1 cycle): BL = data, BL_OE = 1, WL = 0.
- PULSE (WE_CYCLES cycles): WL[addr] = 1, other WL bits 0; BL/BL_OE unchanged.
- HOLD (1 cycle): WL = 0; BL/BL_OE still driven. Then go to RESP.
- READ (RE_CYCLES cycles): BL_OE = 0, WLR[addr] = 1. Register BL_IN in the last cycle. Then go to RESP.
- RESP: rsp_valid = 1; stay until rsp_ready; then go to IDLE. BL_OE = 0 and BL returns to 0 on leaving HOLD.
- WL and WLR are never both nonzero. At most one bit across WL|WLR is set at any time.
- Pulse and read counters are sized ceil(log2(max(WE_CYCLES, RE_CYCLES)+1)) bits and are reloaded on each entry to their state.
- cmd_ready = 0 in every state except IDLE; commands are never queued.

## Timing
- Reset (RSTN low, asynchronous): state IDLE, and WL = 0, WLR = 0, BL = 0, BL_OE = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, counters 0. Must take effect without a clock edge. Mid-pulse reset drops WL immediately and leaves the row undefined. cmd_ready = 1 from the first edge after release.
- Write, accepted at edge 0:
  - SETUP is in cycle 1.
  - WL high in cycles 2..1+WE_CYCLES.
  - HOLD is in cycle 2+WE_CYCLES.
  - rsp_valid rises in cycle 3+WE_CYCLES.
- Read, accepted at edge 0:
  - WLR high in cycles 1..RE_CYCLES.
  - rsp_valid rises in cycle 1+RE_CYCLES with registered data.
- Error: rsp_valid rises in cycle 1.
- rsp_ready asserted in the first RESP cycle gives cmd_ready = 1 in the next cycle. Minimum write throughput is one command per 4+WE_CYCLES cycles.
- rsp_data/rsp_err stay stable while rsp_valid && !rsp_ready.
- cmd_* inputs may change freely after accept; registered copies are used.

## Test plan
- Reset: hold RSTN low with cmd_valid = 1 → all outputs 0 and cmd_ready = 1 after release. Assert RSTN in the 2nd PULSE cycle → WL goes to 0 asynchronously in the same cycle, with no response.
- Write addr 5, data 8'hA5, WE_CYCLES = 2 → BL = A5 with BL_OE = 1 in cycles 1–4, WL = 16'h0020 in cycles 2–3, rsp_valid in cycle 5 with rsp_data = 0 and rsp_err = 0. Write to addr 15 and addr 0 hits the WL edges.
- Read addr 3 with BL_IN = 8'h3C during WLR → WLR = 16'h0008 for RE_CYCLES, BL_OE = 0, rsp_data = 3C. BL_IN changing after sampling does not alter rsp_data.
- Backpressure: hold rsp_ready = 0 for 10 cycles → rsp_valid and rsp_data held, cmd_ready = 0, a second cmd_valid is not accepted. Release → one response consumed, next command accepted the following cycle.
- Out of range: NUM_WL = 12, addr 13 → rsp_err = 1 in cycle 1, and WL, WLR and BL_OE stay 0 throughout.
- Back-to-back random writes then reads over all rows against a behavioural SRAM row model → read-back matches. WL/WLR one-hot-or-zero and mutual exclusion hold every cycle.
